// File: rtl/argo_chan_recv_pkg.sv
// ---------------------------------------------------------------------------
// argo_chan_recv_pkg
//   Shared definitions for the Argo channel receive endpoint.
//   - recv_state_t : 2-bit FSM state encoding (IDLE, WAIT, LAT, HOLD)
//   - req_target() : where a freshly sampled receive request goes
// ---------------------------------------------------------------------------
package argo_chan_recv_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,   // no request outstanding
        ST_WAIT = 2'd1,   // request accepted, waiting for a non-empty FIFO
        ST_LAT  = 2'd2,   // pop issued, waiting out one cycle of RAM latency
        ST_HOLD = 2'd3    // result held for the process until acknowledged
    } recv_state_t;

    // A non-blocking try on an empty FIFO resolves immediately as a miss;
    // every other request goes to WAIT. A non-empty FIFO cannot become
    // empty again without a pop, so WAIT is guaranteed to pop next cycle.
    function automatic recv_state_t req_target(input logic nb, input logic empty);
        return (nb && empty) ? ST_HOLD : ST_WAIT;
    endfunction

endpackage

// File: rtl/argo_recv_timer.sv
// ---------------------------------------------------------------------------
// argo_recv_timer
//   Blocking-wait timeout counter for argo_chan_recv. Only instantiated when
//   ARGO_RECV_TIMEOUT_EN is defined.
// Ports
//   i_clk     : clock
//   i_rst     : asynchronous active-high reset
//   i_active  : receiver is in WAIT; counter is held at zero otherwise
//   i_inc     : a WAIT cycle with the FIFO empty
//   o_expire  : this empty WAIT cycle is the TIMEOUT_CYCLES-th one
// ---------------------------------------------------------------------------
module argo_recv_timer #(
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_active,
    input  logic i_inc,
    output logic o_expire
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] r_cnt;

    // Holding the count at zero outside WAIT gives the clear-on-entry
    // behaviour without having to detect the entry edge.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (!i_active) begin
            r_cnt <= '0;
        end else if (i_inc) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Expire combinationally on the limit cycle so the FSM leaves WAIT on
    // exactly the TIMEOUT_CYCLES-th empty edge.
    assign o_expire = i_active && i_inc && (r_cnt == CW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/argo_chan_recv.sv
// ---------------------------------------------------------------------------
// argo_chan_recv
//   Receive endpoint of an Argo channel. Converts a process's blocking or
//   non-blocking receive into exactly one safe FIFO pop, absorbs the FIFO
//   read latency and holds the result until the process acknowledges it.
//
// Optional feature macro: ARGO_RECV_TIMEOUT_EN
//   Defined   : blocking waits give up after TIMEOUT_CYCLES empty cycles.
//   Undefined : blocking waits never time out; o_recv_timeout is constant 0.
//
// Ports
//   i_clk, i_rst    : clock, asynchronous active-high reset
//   i_recv_req      : process requests one element (IDLE, or HOLD with ack)
//   i_recv_nb       : qualifies the request as a non-blocking try
//   i_recv_ack      : process consumes the held result
//   o_recv_valid    : result is held (HOLD)
//   o_recv_ok       : o_recv_data is a real element
//   o_recv_data     : received element, 0 when not ok
//   o_recv_timeout  : result came from a timeout
//   o_recv_count    : successful pops since reset (wraps)
//   o_fifo_rd_en    : pop strobe to the FIFO (combinational)
//   i_fifo_rd_data  : FIFO read data
//   i_fifo_empty    : FIFO empty flag
// ---------------------------------------------------------------------------
module argo_chan_recv
    import argo_chan_recv_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int RD_LATENCY     = 1,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_recv_req,
    input  logic                  i_recv_nb,
    input  logic                  i_recv_ack,
    output logic                  o_recv_valid,
    output logic                  o_recv_ok,
    output logic [DATA_WIDTH-1:0] o_recv_data,
    output logic                  o_recv_timeout,
    output logic [31:0]           o_recv_count,
    output logic                  o_fifo_rd_en,
    input  logic [DATA_WIDTH-1:0] i_fifo_rd_data,
    input  logic                  i_fifo_empty
);

    generate
        if (RD_LATENCY != 0 && RD_LATENCY != 1) begin : g_bad_latency
            $error("argo_chan_recv: RD_LATENCY must be 0 or 1");
        end
        if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
            $error("argo_chan_recv: TIMEOUT_CYCLES must be >= 1");
        end
    endgenerate

    recv_state_t           r_state;
    recv_state_t           w_state_next;
    logic                  w_capture;
    logic                  w_ok_next;
    logic                  w_timeout_next;
    logic [DATA_WIDTH-1:0] w_data_next;
    logic                  w_expire;
    logic                  w_waiting;

    logic                  r_ok;
    logic                  r_timeout;
    logic [DATA_WIDTH-1:0] r_data;
    logic [31:0]           r_count;

    assign w_waiting = (r_state == ST_WAIT);

    // Gating with i_rst drops the strobe in the very cycle reset rises,
    // before the asynchronous state clear has propagated.
    assign o_fifo_rd_en = w_waiting && !i_fifo_empty && !i_rst;

`ifdef ARGO_RECV_TIMEOUT_EN
    argo_recv_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timer (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_active (w_waiting),
        .i_inc    (w_waiting && i_fifo_empty),
        .o_expire (w_expire)
    );
`else
    assign w_expire = 1'b0;
`endif

    always_comb begin
        w_state_next   = r_state;
        w_capture      = 1'b0;
        w_ok_next      = 1'b0;
        w_timeout_next = 1'b0;
        w_data_next    = '0;
        unique case (r_state)
            ST_IDLE: begin
                if (i_recv_req) begin
                    w_state_next = req_target(i_recv_nb, i_fifo_empty);
                    w_capture    = (w_state_next == ST_HOLD);   // try-miss result
                end
            end
            ST_WAIT: begin
                // A pop always beats a timeout landing on the same cycle.
                if (!i_fifo_empty) begin
                    if (RD_LATENCY == 0) begin
                        w_state_next = ST_HOLD;
                        w_capture    = 1'b1;
                        w_ok_next    = 1'b1;
                        w_data_next  = i_fifo_rd_data;
                    end else begin
                        w_state_next = ST_LAT;
                    end
                end else if (w_expire) begin
                    w_state_next   = ST_HOLD;
                    w_capture      = 1'b1;
                    w_timeout_next = 1'b1;
                end
            end
            ST_LAT: begin
                w_state_next = ST_HOLD;
                w_capture    = 1'b1;
                w_ok_next    = 1'b1;
                w_data_next  = i_fifo_rd_data;
            end
            ST_HOLD: begin
                if (i_recv_ack) begin
                    if (i_recv_req) begin
                        w_state_next = req_target(i_recv_nb, i_fifo_empty);
                        w_capture    = (w_state_next == ST_HOLD);
                    end else begin
                        w_state_next = ST_IDLE;
                    end
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state   <= ST_IDLE;
            r_ok      <= 1'b0;
            r_timeout <= 1'b0;
            r_data    <= '0;
            r_count   <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_capture) begin
                r_ok      <= w_ok_next;
                r_timeout <= w_timeout_next;
                r_data    <= w_data_next;
                if (w_ok_next) begin
                    r_count <= r_count + 32'd1;
                end
            end
        end
    end

    assign o_recv_valid   = (r_state == ST_HOLD);
    assign o_recv_ok      = r_ok;
    assign o_recv_data    = r_data;
    assign o_recv_count   = r_count;
`ifdef ARGO_RECV_TIMEOUT_EN
    assign o_recv_timeout = r_timeout;
`else
    assign o_recv_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_argo_chan_recv.sv
// ---------------------------------------------------------------------------
// tb_argo_chan_recv
//   Self-checking bench for argo_chan_recv (RD_LATENCY=1). A small FIFO model
//   feeds the DUT; a queue of pushed-but-unconsumed values plus a success
//   counter forms the reference model. Timeout scenarios run only when
//   ARGO_RECV_TIMEOUT_EN is defined (TIMEOUT_CYCLES=8).
// ---------------------------------------------------------------------------
module tb_argo_chan_recv;

    localparam int DW = 32;
`ifdef ARGO_RECV_TIMEOUT_EN
    localparam int TO    = 8;
    localparam int WAITN = 5;
`else
    localparam int TO    = 256;
    localparam int WAITN = 10;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req = 1'b0;
    logic          nb  = 1'b0;
    logic          ack = 1'b0;
    logic          valid, ok, timeout, rd_en;
    logic [DW-1:0] data;
    logic [31:0]   count;
    logic [DW-1:0] fifo_rd_data = '0;
    logic          fifo_empty;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    argo_chan_recv #(
        .DATA_WIDTH     (DW),
        .RD_LATENCY     (1),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_recv_req     (req),
        .i_recv_nb      (nb),
        .i_recv_ack     (ack),
        .o_recv_valid   (valid),
        .o_recv_ok      (ok),
        .o_recv_data    (data),
        .o_recv_timeout (timeout),
        .o_recv_count   (count),
        .o_fifo_rd_en   (rd_en),
        .i_fifo_rd_data (fifo_rd_data),
        .i_fifo_empty   (fifo_empty)
    );

    // ---------------- FIFO model (1-cycle read latency) ----------------
    logic [DW-1:0] mem [0:63];
    int wr_ptr = 0;
    int rd_ptr = 0;
    int pulse_cnt = 0;
    int underflow_cnt = 0;

    assign fifo_empty = (wr_ptr == rd_ptr);

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= wr_ptr;
        end else if (rd_en) begin
            fifo_rd_data <= mem[rd_ptr % 64];
            rd_ptr       <= rd_ptr + 1;
        end
    end

    always @(posedge clk) if (rd_en) pulse_cnt <= pulse_cnt + 1;
    always @(negedge clk) if (!rst && rd_en && fifo_empty) underflow_cnt <= underflow_cnt + 1;

    // ---------------- reference model ----------------
    logic [DW-1:0] exp_q [$];
    int            model_count = 0;

    task automatic push(input logic [DW-1:0] v);
        mem[wr_ptr % 64] = v;
        wr_ptr = wr_ptr + 1;
        exp_q.push_back(v);
    endtask

    task automatic wait_valid(input int budget, output bit got);
        got = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (valid) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        @(negedge clk);
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", valid); end
        checks++; if (ok !== 1'b0) begin errors++; $display("FAIL reset_ok: got %b want 0", ok); end
        checks++; if (data !== '0) begin errors++; $display("FAIL reset_data: got %h want 0", data); end
        checks++; if (count !== 32'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", count); end
        checks++; if (rd_en !== 1'b0) begin errors++; $display("FAIL reset_rd_en: got %b want 0", rd_en); end
        rst = 1'b0;
        @(negedge clk);
        $display("test_reset: outputs cleared");
    endtask

    task automatic test_blocking;
        bit got;
        int p0 = pulse_cnt;
        logic [DW-1:0] e;
        req = 1'b1; nb = 1'b0;
        @(negedge clk);
        req = 1'b0;
        repeat (WAITN) @(negedge clk);
        checks++; if (valid !== 1'b0 || pulse_cnt != p0) begin errors++; $display("FAIL blocking_wait: valid=%b pulses=%0d want 0/0", valid, pulse_cnt - p0); end
        push(32'hCAFE0001);
        wait_valid(10, got);
        checks++; if (!got) begin errors++; $display("FAIL blocking_valid: no valid within budget"); end
        e = exp_q.pop_front(); model_count++;
        checks++; if (data !== e || ok !== 1'b1) begin errors++; $display("FAIL blocking_data: got %h ok=%b want %h ok=1", data, ok, e); end
        checks++; if (count !== model_count) begin errors++; $display("FAIL blocking_count: got %0d want %0d", count, model_count); end
        checks++; if (pulse_cnt - p0 != 1) begin errors++; $display("FAIL blocking_pulses: got %0d want 1", pulse_cnt - p0); end
        ack = 1'b1; @(negedge clk); ack = 1'b0;
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL blocking_ack: valid=%b want 0", valid); end
        $display("test_blocking: data=%h count=%0d", e, model_count);
    endtask

    task automatic test_try_miss;
        int p0 = pulse_cnt;
        req = 1'b1; nb = 1'b1;
        @(negedge clk);
        req = 1'b0; nb = 1'b0;
        checks++; if (valid !== 1'b1 || ok !== 1'b0 || data !== '0) begin errors++; $display("FAIL try_miss: valid=%b ok=%b data=%h want 1/0/0", valid, ok, data); end
        repeat (3) @(negedge clk);
        checks++; if (pulse_cnt != p0 || valid !== 1'b1 || count !== model_count) begin errors++; $display("FAIL try_miss_hold: pulses=%0d valid=%b count=%0d want 0/1/%0d", pulse_cnt - p0, valid, count, model_count); end
        ack = 1'b1; @(negedge clk); ack = 1'b0;
        $display("test_try_miss: miss held");
    endtask

    task automatic test_back_to_back;
        int p0 = pulse_cnt;
        int cyc = 0;
        int n = 0;
        int last = 0;
        bit got;
        logic [DW-1:0] e;
        for (int i = 1; i <= 4; i++) push(DW'(i));
        req = 1'b1; ack = 1'b1; nb = 1'b0;
        while (n < 4 && cyc < 40) begin
            @(negedge clk); cyc++;
            if (valid) begin
                e = exp_q.pop_front(); model_count++;
                checks++; if (data !== e || ok !== 1'b1) begin errors++; $display("FAIL b2b_data: got %h want %h", data, e); end
                if (n > 0) begin
                    checks++; if (cyc - last != 3) begin errors++; $display("FAIL b2b_spacing: got %0d want 3", cyc - last); end
                end
                last = cyc; n++;
            end
        end
        checks++; if (n != 4) begin errors++; $display("FAIL b2b_budget: got %0d elements want 4", n); end
        repeat (3) @(negedge clk);
        checks++; if (valid !== 1'b0 || pulse_cnt - p0 != 4) begin errors++; $display("FAIL b2b_idle_wait: valid=%b pulses=%0d want 0/4", valid, pulse_cnt - p0); end
        checks++; if (count !== model_count) begin errors++; $display("FAIL b2b_count: got %0d want %0d", count, model_count); end
        req = 1'b0; ack = 1'b0;
        push(32'h99);
        wait_valid(10, got);
        e = exp_q.pop_front(); model_count++;
        checks++; if (!got || data !== e) begin errors++; $display("FAIL b2b_tail: got %h valid=%b want %h", data, got, e); end
        ack = 1'b1; @(negedge clk); ack = 1'b0;
        $display("test_back_to_back: %0d elements, count=%0d", n, model_count);
    endtask

    task automatic test_random;
        bit got;
        bit miss;
        logic [DW-1:0] e;
        logic [DW-1:0] held;
        for (int t = 0; t < 25 || exp_q.size() > 0; t++) begin
            if (t < 25) begin
                repeat ($urandom_range(0, 2)) push($urandom);
                nb = 1'($urandom_range(0, 1));
            end else begin
                nb = 1'b0;
            end
            miss = nb && (exp_q.size() == 0);
            req = 1'b1;
            @(negedge clk);
            req = 1'b0; nb = 1'b0;
            if (!miss && exp_q.size() == 0) begin
                repeat ($urandom_range(0, 4)) @(negedge clk);
                push($urandom);
            end
            wait_valid(20, got);
            checks++; if (!got) begin errors++; $display("FAIL rand_valid[%0d]: no valid within budget", t); end
            if (miss) e = '0;
            else begin e = exp_q.pop_front(); model_count++; end
            checks++; if (data !== e || ok !== !miss || timeout !== 1'b0) begin errors++; $display("FAIL rand_result[%0d]: got %h ok=%b to=%b want %h ok=%b to=0", t, data, ok, timeout, e, !miss); end
            checks++; if (count !== model_count) begin errors++; $display("FAIL rand_count[%0d]: got %0d want %0d", t, count, model_count); end
            held = data;
            repeat ($urandom_range(0, 3)) begin
                @(negedge clk);
                checks++; if (data !== held || valid !== 1'b1) begin errors++; $display("FAIL rand_hold[%0d]: got %h valid=%b want %h valid=1", t, data, valid, held); end
            end
            ack = 1'b1; @(negedge clk); ack = 1'b0;
            $display("test_random[%0d]: miss=%b data=%h count=%0d", t, miss, e, model_count);
        end
    endtask

    task automatic test_hold_stability;
        bit got;
        int p0;
        logic [DW-1:0] e;
        push(32'h55);
        req = 1'b1; nb = 1'b0;
        @(negedge clk);
        req = 1'b0;
        wait_valid(10, got);
        e = exp_q.pop_front(); model_count++;
        checks++; if (!got || data !== e) begin errors++; $display("FAIL hold_first: got %h want %h", data, e); end
        p0 = pulse_cnt;
        for (int i = 0; i < 20; i++) begin
            if (i < 5) push($urandom);
            @(negedge clk);
            checks++; if (data !== 32'h55 || valid !== 1'b1) begin errors++; $display("FAIL hold_stable[%0d]: got %h valid=%b want 55 valid=1", i, data, valid); end
        end
        checks++; if (pulse_cnt != p0) begin errors++; $display("FAIL hold_no_pop: got %0d pulses want 0", pulse_cnt - p0); end
        ack = 1'b1; @(negedge clk); ack = 1'b0;
        $display("test_hold_stability: data held at 55");
    endtask

    task automatic test_reset_mid_wait;
        req = 1'b1; nb = 1'b0;
        @(negedge clk);
        req = 1'b0;
        checks++; if (rd_en !== 1'b1) begin errors++; $display("FAIL midwait_pre_rd_en: got %b want 1", rd_en); end
        #1 rst = 1'b1;
        #1;
        checks++; if (rd_en !== 1'b0) begin errors++; $display("FAIL midwait_rd_en: got %b want 0", rd_en); end
        checks++; if (valid !== 1'b0 || ok !== 1'b0 || timeout !== 1'b0 || data !== '0) begin errors++; $display("FAIL midwait_outputs: valid=%b ok=%b to=%b data=%h want zeros", valid, ok, timeout, data); end
        checks++; if (count !== 32'd0) begin errors++; $display("FAIL midwait_count: got %0d want 0", count); end
        exp_q.delete(); model_count = 0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++; if (valid !== 1'b0 || rd_en !== 1'b0) begin errors++; $display("FAIL midwait_after: valid=%b rd_en=%b want 0/0", valid, rd_en); end
        $display("test_reset_mid_wait: reset mid-pop");
    endtask

`ifdef ARGO_RECV_TIMEOUT_EN
    task automatic test_timeout;
        bit got;
        logic [DW-1:0] e;
        req = 1'b1; nb = 1'b0;
        @(negedge clk);
        req = 1'b0;
        for (int i = 0; i < TO; i++) begin
            checks++; if (valid !== 1'b0) begin errors++; $display("FAIL timeout_early[%0d]: valid=%b want 0", i, valid); end
            @(negedge clk);
        end
        checks++; if (valid !== 1'b1 || timeout !== 1'b1 || ok !== 1'b0 || data !== '0) begin errors++; $display("FAIL timeout_hit: valid=%b to=%b ok=%b data=%h want 1/1/0/0", valid, timeout, ok, data); end
        checks++; if (count !== model_count) begin errors++; $display("FAIL timeout_count: got %0d want %0d", count, model_count); end
        ack = 1'b1; @(negedge clk); ack = 1'b0;
        req = 1'b1;
        @(negedge clk);
        req = 1'b0;
        repeat (TO - 1) @(negedge clk);
        push(32'hABCD);
        wait_valid(6, got);
        e = exp_q.pop_front(); model_count++;
        checks++; if (!got || timeout !== 1'b0 || ok !== 1'b1 || data !== e) begin errors++; $display("FAIL timeout_race: valid=%b to=%b ok=%b data=%h want 1/0/1/%h", got, timeout, ok, data, e); end
        ack = 1'b1; @(negedge clk); ack = 1'b0;
        $display("test_timeout: limit and race checked");
    endtask
`endif

    task automatic test_no_underflow;
        checks++; if (underflow_cnt != 0) begin errors++; $display("FAIL underflow: got %0d rd_en-while-empty cycles want 0", underflow_cnt); end
    endtask

    initial begin
        test_reset();
        test_blocking();
        test_try_miss();
        test_back_to_back();
        test_random();
        test_hold_stability();
`ifdef ARGO_RECV_TIMEOUT_EN
        test_timeout();
`endif
        test_reset_mid_wait();
        test_no_underflow();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
